branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 70 +++++++
 tb/tb_branch_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// branch_unit: resolves conditional branches into a registered, stallable result with delivery statistics
module branch_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [2:0]       funct3,
  input  logic [12:0]      imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  next_pc,
  output logic             misaligned,
  output logic             illegal,
  output logic [CNT_W-1:0] resolved_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  logic accept, hs, ill, eq, lt, ltu, cmp, tk;
  logic [XLEN-1:0] tgt, seq;
  assign in_ready = !out_valid || out_ready;
  always_comb begin
    accept = in_valid && in_ready;
    hs     = out_valid && out_ready;
    ill    = funct3[2:1] == 2'b01;
    eq     = rs1_data == rs2_data;
    lt     = $signed(rs1_data) < $signed(rs2_data);
    ltu    = rs1_data < rs2_data;
    cmp    = funct3[2] ? (funct3[1] ? ltu : lt) : eq;
    tk     = !ill && (cmp ^ funct3[0]);
    tgt    = pc + {{(XLEN-12){imm[12]}}, imm[11:1], 1'b0};
    seq    = pc + XLEN'(4);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      taken        <= 1'b0;
      misaligned   <= 1'b0;
      illegal      <= 1'b0;
      target       <= '0;
      next_pc      <= '0;
      resolved_cnt <= '0;
      taken_cnt    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (hs) begin
        resolved_cnt <= resolved_cnt + CNT_W'(resolved_cnt != '1);
        taken_cnt    <= taken_cnt + CNT_W'(taken && taken_cnt != '1);
      end
      if (accept) begin
        out_valid  <= 1'b1;
        taken      <= tk;
        misaligned <= tk && tgt[1];
        illegal    <= ill;
        target     <= tgt;
        next_pc    <= tk ? tgt : seq;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed stimulus checked every cycle against a behavioural model plus literal expectations
module tb_branch_unit;
  localparam int CW = 4;
  logic clk = 1'b0, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic taken, misaligned, illegal;
  logic [31:0] pc, rs1_data, rs2_data, target, next_pc;
  logic [2:0] funct3;
  logic [12:0] imm;
  logic [CW-1:0] resolved_cnt, taken_cnt;
  int n_chk = 0, n_fail = 0;
  logic m_valid, m_taken, m_mis, m_ill;
  logic [31:0] m_tg, m_np;
  int m_res, m_tk;
  branch_unit #(.XLEN(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .funct3(funct3), .imm(imm),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .target(target), .next_pc(next_pc), .misaligned(misaligned), .illegal(illegal),
    .resolved_cnt(resolved_cnt), .taken_cnt(taken_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void ref_br(input logic [31:0] p, a, b, input logic [2:0] f, input logic [12:0] im,
                                 output logic t, output logic [31:0] tg, output logic [31:0] np,
                                 output logic mi, output logic il);
    int off;
    off = int'($signed({im[12:1], 1'b0}));
    tg = 32'(longint'(p) + longint'(off));
    case (f)
      3'd0: t = a == b;
      3'd1: t = a != b;
      3'd4: t = $signed(a) < $signed(b);
      3'd5: t = $signed(a) >= $signed(b);
      3'd6: t = a < b;
      3'd7: t = a >= b;
      default: t = 1'b0;
    endcase
    il = f == 3'd2 || f == 3'd3;
    np = t ? tg : 32'(longint'(p) + 4);
    mi = t && tg[1];
  endfunction
  always @(posedge clk) begin
    logic hs, acc;
    if (rst) begin
      m_valid = 0; m_taken = 0; m_mis = 0; m_ill = 0; m_tg = 0; m_np = 0; m_res = 0; m_tk = 0;
    end else if (!flush) begin
      hs  = m_valid && out_ready;
      acc = in_valid && (!m_valid || out_ready);
      if (hs) begin
        if (m_res < 15) m_res++;
        if (m_taken && m_tk < 15) m_tk++;
      end
      if (acc) begin
        ref_br(pc, rs1_data, rs2_data, funct3, imm, m_taken, m_tg, m_np, m_mis, m_ill);
        m_valid = 1;
      end else if (hs) m_valid = 0;
    end else m_valid = 0;
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    check("taken", 32'(taken), 32'(m_taken));
    check("misaligned", 32'(misaligned), 32'(m_mis));
    check("illegal", 32'(illegal), 32'(m_ill));
    check("target", target, m_tg);
    check("next_pc", next_pc, m_np);
    check("resolved_cnt", 32'(resolved_cnt), 32'(m_res));
    check("taken_cnt", 32'(taken_cnt), 32'(m_tk));
  end
  task automatic drive(input logic [31:0] p, a, b, input logic [2:0] f, input logic [12:0] im);
    pc = p; rs1_data = a; rs2_data = b; funct3 = f; imm = im; in_valid = 1'b1;
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  initial begin
    logic [31:0] ops [3][2];
    ops = '{'{32'd5, 32'd5}, '{32'd3, 32'd7}, '{32'h8000_0000, 32'd1}};
    rst = 1; in_valid = 0; flush = 0; out_ready = 1;
    pc = 0; rs1_data = 0; rs2_data = 0; funct3 = 0; imm = 0;
    tick(); tick();
    check("lit_rst_valid", 32'(out_valid), 0);
    check("lit_rst_next_pc", next_pc, 0);
    rst = 0;
    check("lit_ready_after_rst", 32'(in_ready), 1);
    drive(32'h100, 5, 5, 3'b000, 13'h010);
    tick();
    check("lit_beq_valid", 32'(out_valid), 1);
    check("lit_beq_taken", 32'(taken), 1);
    check("lit_beq_target", target, 32'h110);
    check("lit_beq_next_pc", next_pc, 32'h110);
    check("lit_beq_mis", 32'(misaligned), 0);
    drive(32'h200, 32'hFFFF_FFFF, 1, 3'b100, 13'h1FF8);
    tick();
    check("lit_blt_taken", 32'(taken), 1);
    check("lit_blt_target", target, 32'h1F8);
    drive(32'h200, 32'hFFFF_FFFF, 1, 3'b110, 13'h1FF8);
    tick();
    check("lit_bltu_taken", 32'(taken), 0);
    check("lit_bltu_next_pc", next_pc, 32'h204);
    drive(32'h300, 1, 2, 3'b001, 13'h020);
    tick();
    check("lit_bne_next_pc", next_pc, 32'h320);
    out_ready = 0;
    drive(32'h400, 2, 2, 3'b111, 13'h040);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lit_stall_ready", 32'(in_ready), 0);
      check("lit_stall_next_pc", next_pc, 32'h320);
      check("lit_stall_valid", 32'(out_valid), 1);
    end
    out_ready = 1;
    tick();
    check("lit_resume_valid", 32'(out_valid), 1);
    check("lit_resume_next_pc", next_pc, 32'h440);
    drive(32'h500, 7, 7, 3'b010, 13'h010);
    tick();
    check("lit_ill_illegal", 32'(illegal), 1);
    check("lit_ill_taken", 32'(taken), 0);
    check("lit_ill_next_pc", next_pc, 32'h504);
    check("lit_ill_target", target, 32'h510);
    drive(32'h600, 9, 9, 3'b000, 13'h002);
    tick();
    check("lit_mis_mis", 32'(misaligned), 1);
    check("lit_mis_next_pc", next_pc, 32'h602);
    drive(32'h700, 1, 1, 3'b000, 13'h010);
    flush = 1;
    tick();
    flush = 0;
    check("lit_flush_valid", 32'(out_valid), 0);
    check("lit_flush_resolved", 32'(resolved_cnt), 6);
    check("lit_flush_taken_cnt", 32'(taken_cnt), 4);
    for (int f = 0; f < 8; f++)
      for (int k = 0; k < 3; k++) begin
        drive(32'h1000 + 32'(f * 16 + k * 4), ops[k][0], ops[k][1], 3'(f), 13'h1FF0 + 13'(k * 6));
        tick();
      end
    drive(32'hFFFF_FFFC, 1, 2, 3'b110, 13'h008);
    tick();
    check("lit_wrap_target", target, 32'h4);
    for (int i = 0; i < 20; i++) begin
      drive(32'h2000 + 32'(i * 4), 3, 3, 3'b000, 13'h040);
      tick();
    end
    in_valid = 0;
    tick();
    check("lit_sat_resolved", 32'(resolved_cnt), 15);
    check("lit_sat_taken", 32'(taken_cnt), 15);
    drive(32'h3000, 4, 4, 3'b000, 13'h010);
    tick();
    rst = 1;
    tick();
    check("lit_midrst_valid", 32'(out_valid), 0);
    check("lit_midrst_target", target, 0);
    check("lit_midrst_resolved", 32'(resolved_cnt), 0);
    check("lit_midrst_taken_cnt", 32'(taken_cnt), 0);
    rst = 0; in_valid = 0;
    check("lit_midrst_ready", 32'(in_ready), 1);
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
